// File: rtl/fetch_sequencer.sv
// Program counter and instruction register sequencer sitting between instruction memory and decode.
// Optional macro FETCH_WRAP_HALT_EN: a load from the last address drains and halts instead of wrapping on.
module fetch_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int INSTR_W  = 17,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ir_enable,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_e;

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
`ifdef FETCH_WRAP_HALT_EN
  localparam logic [ADDR_W-1:0] LastAddr = '1;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               load;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    load       = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        // A redirect wins over both loading and consuming; the target is fetched next cycle.
        load = !redirect_valid && (!ir_valid_q || ir_ready);
        if (redirect_valid) begin
          pc_d       = redirect_addr;
          ir_valid_d = 1'b0;
        end else if (load) begin
          ir_d       = imem_instr;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
        end
        if (halt_req) state_d = DRAIN;
`ifdef FETCH_WRAP_HALT_EN
        if (load && (pc_q == LastAddr)) state_d = DRAIN;
`endif
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d       = redirect_addr;
          ir_valid_d = 1'b0;
        end
        if (!ir_valid_q || ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = HALTED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= ResetPc;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir_enable = load;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign halted    = (state_q == HALTED);

endmodule
